// File: rtl/bg_sram_ctrl_pkg.sv
// Shared types and address-mapping constants for the background tile-ROM SRAM controller.
package bg_sram_ctrl_pkg;

    localparam int ADDR_W     = 17;  // byte address width on the download side and word address width on SRAM
    localparam int OFF_W      = 15;  // ROM offset width
    localparam int ROM_SEL_HI = 16;  // ROM-select bit that picks the even/odd SRAM word
    localparam int ROM_SEL_LO = 15;  // ROM-select bit that picks the byte lane (1 = UB)
    localparam int DQ_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SET,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD0,
        S_RD0_CAP,
        S_RD1,
        S_RD1_CAP
    } state_t;

endpackage

// File: rtl/bg_sram_ctrl_if.sv
// Loader / background-layer side of the controller: download writes and row fetches.
interface bg_sram_ctrl_if;
    import bg_sram_ctrl_pkg::*;

    logic              dl_active;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_busy;
    logic              fetch_req;
    logic [OFF_W-1:0]  fetch_addr;
    logic              fetch_ack;
    logic [7:0]        DO_1, DO_2, DO_3, DO_4;

    modport master (
        output dl_active, dn_wr, dn_addr, dn_data, fetch_req, fetch_addr,
        input  dn_busy, fetch_ack, DO_1, DO_2, DO_3, DO_4
    );

    modport slave (
        input  dl_active, dn_wr, dn_addr, dn_data, fetch_req, fetch_addr,
        output dn_busy, fetch_ack, DO_1, DO_2, DO_3, DO_4
    );
endinterface

// File: rtl/bg_sram_map.sv
// Byte-address to SRAM word/lane mapper. ROMs 0/1 share even words, ROMs 2/3 odd words;
// the low ROM-select bit picks the byte lane.
module bg_sram_map
    import bg_sram_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] byte_addr,
    output logic [ADDR_W-1:0] word_addr,
    output logic              ub_sel
);
    assign word_addr = {1'b0, byte_addr[OFF_W-1:0], byte_addr[ROM_SEL_HI]};
    assign ub_sel    = byte_addr[ROM_SEL_LO];
endmodule

// File: rtl/bg_sram_ctrl.sv
// Single-port async SRAM controller: one-entry download write buffer, one-entry
// (latest-wins) fetch buffer, and an FSM that owns every SRAM pin.
module bg_sram_ctrl
    import bg_sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 2
) (
    input  logic              master_clk,
    input  logic              RST_N,
    bg_sram_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DQ_W-1:0]   SRAM_DQ,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    state_t            state;
    logic [7:0]        cnt;
    logic              wbuf_vld;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [7:0]        wbuf_data;
    logic              f_vld;
    logic [OFF_W-1:0]  f_addr;
    logic [OFF_W-1:0]  cur_addr;
    logic [DQ_W-1:0]   stage0;
    logic              dq_oe;
    logic [DQ_W-1:0]   dq_out;
    logic              busy_q;
    logic              ack_q;
    logic [7:0]        do1, do2, do3, do4;

    logic              wr_take, fetch_take, wr_pend, rd_go, rd_consume;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic [OFF_W-1:0]  rd_src;
    logic [ADDR_W-1:0] map_in, map_word;
    logic              map_ub;

    // A write is only accepted while nothing is buffered or in flight.
    assign wr_take    = bus.dn_wr && !busy_q;
    assign fetch_take = bus.fetch_req && !bus.dl_active;
    assign wr_pend    = wbuf_vld || wr_take;
    assign rd_go      = (f_vld && !bus.dl_active) || fetch_take;
    assign rd_consume = (state == S_IDLE) && !wr_pend && rd_go;

    // IDLE can launch straight from the incoming strobe; later states use the buffers.
    assign w_addr = wbuf_vld ? wbuf_addr : bus.dn_addr;
    assign w_data = wbuf_vld ? wbuf_data : bus.dn_data;
    assign rd_src = (state == S_IDLE) ? (fetch_take ? bus.fetch_addr : f_addr) : cur_addr;

    // Reads reuse the write mapping: word select sits in the ROM-select-high position, lane bit 0.
    assign map_in = ((state == S_IDLE) && wr_pend) ? w_addr
                                                    : {(state == S_RD0_CAP), 1'b0, rd_src};

    bg_sram_map u_map (
        .byte_addr (map_in),
        .word_addr (map_word),
        .ub_sel    (map_ub)
    );

    assign SRAM_DQ       = dq_oe ? dq_out : {DQ_W{1'bz}};
    assign bus.dn_busy   = busy_q;
    assign bus.fetch_ack = ack_q;
    assign bus.DO_1      = do1;
    assign bus.DO_2      = do2;
    assign bus.DO_3      = do3;
    assign bus.DO_4      = do4;

    // Write buffer and busy flag; busy drops one IDLE cycle after the write sequence ends.
    always_ff @(posedge master_clk or negedge RST_N) begin
        if (!RST_N) begin
            wbuf_vld  <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (wr_take) begin
                wbuf_vld  <= 1'b1;
                wbuf_addr <= bus.dn_addr;
                wbuf_data <= bus.dn_data;
            end else if (state == S_WR_HOLD) begin
                wbuf_vld  <= 1'b0;
            end
            if (wr_take)
                busy_q <= 1'b1;
            else if ((state == S_IDLE) && !wbuf_vld)
                busy_q <= 1'b0;
        end
    end

    // Fetch buffer: a newer request overwrites an older one that has not started.
    always_ff @(posedge master_clk or negedge RST_N) begin
        if (!RST_N) begin
            f_vld  <= 1'b0;
            f_addr <= '0;
        end else if (rd_consume) begin
            f_vld  <= 1'b0;
        end else if (fetch_take) begin
            f_vld  <= 1'b1;
            f_addr <= bus.fetch_addr;
        end
    end

    // Sequencer with registered SRAM pins and outputs; writes take priority over reads.
    always_ff @(posedge master_clk or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            SRAM_ADDR <= '0;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            cur_addr  <= '0;
            stage0    <= '0;
            ack_q     <= 1'b0;
            do1       <= '0;
            do2       <= '0;
            do3       <= '0;
            do4       <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_pend) begin
                        state     <= S_WR_SET;
                        SRAM_ADDR <= map_word;
                        SRAM_UB_N <= !map_ub;
                        SRAM_LB_N <= map_ub;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b1;
                        dq_out    <= {w_data, w_data};
                    end else if (rd_go) begin
                        state     <= S_RD0;
                        cur_addr  <= rd_src;
                        SRAM_ADDR <= map_word;
                        SRAM_OE_N <= 1'b0;
                        SRAM_UB_N <= 1'b0;
                        SRAM_LB_N <= 1'b0;
                        cnt       <= 8'(RD_WAIT - 1);
                    end
                end
                S_WR_SET: begin
                    state     <= S_WR_PULSE;
                    SRAM_WE_N <= 1'b0;
                    cnt       <= 8'(WR_PULSE - 1);
                end
                S_WR_PULSE: begin
                    if (cnt == 8'd0) begin
                        state     <= S_WR_HOLD;
                        SRAM_WE_N <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_WR_HOLD: begin
                    state     <= S_IDLE;
                    dq_oe     <= 1'b0;
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                end
                S_RD0: begin
                    if (cnt == 8'd0) state <= S_RD0_CAP;
                    else             cnt   <= cnt - 8'd1;
                end
                S_RD0_CAP: begin
                    stage0    <= SRAM_DQ;
                    state     <= S_RD1;
                    SRAM_ADDR <= map_word;
                    cnt       <= 8'(RD_WAIT - 1);
                end
                S_RD1: begin
                    if (cnt == 8'd0) state <= S_RD1_CAP;
                    else             cnt   <= cnt - 8'd1;
                end
                S_RD1_CAP: begin
                    do1       <= stage0[7:0];
                    do2       <= stage0[15:8];
                    do3       <= SRAM_DQ[7:0];
                    do4       <= SRAM_DQ[15:8];
                    ack_q     <= 1'b1;
                    state     <= S_IDLE;
                    SRAM_OE_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bg_sram_ctrl.sv
// Bench for bg_sram_ctrl: behavioural async SRAM, byte-level ROM reference model,
// table-driven write mapping vectors, hand sequences for corner cases, random traffic.
module tb_bg_sram_ctrl;
    import bg_sram_ctrl_pkg::*;

    logic master_clk = 1'b0;
    logic RST_N;
    always #5 master_clk = ~master_clk;

    bg_sram_ctrl_if bus();

    logic [16:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    bg_sram_ctrl #(.RD_WAIT(1), .WR_PULSE(2)) dut (
        .master_clk (master_clk),
        .RST_N      (RST_N),
        .bus        (bus),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    // Async SRAM: combinational read while OE low, byte-lane write while WE low.
    logic [15:0] mem [0:65535];
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[15:0]] : 16'hzzzz;
    always @(posedge master_clk) begin
        if (!sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[15:0]][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr[15:0]][7:0]  <= sram_dq[7:0];
        end
    end

    // Reference model: the four ROM images, tracked only over a small row window.
    localparam logic [14:0] ROW0 = 15'h1230;
    logic [7:0] rom_m [4][8];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic [16:0] exp_waddr;
        logic        exp_ub_n;
        logic        exp_lb_n;
    } wvec_t;
    wvec_t wt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge master_clk);
        #1;
    endtask

    function automatic logic [31:0] get_do();
        return {bus.DO_1, bus.DO_2, bus.DO_3, bus.DO_4};
    endfunction

    function automatic logic [31:0] exp_row(input logic [14:0] a);
        int i;
        i = int'(a - ROW0);
        return {rom_m[0][i], rom_m[1][i], rom_m[2][i], rom_m[3][i]};
    endfunction

    task automatic wait_idle;
        int n;
        n = 0;
        while (bus.dn_busy && n < 60) begin
            tick;
            n++;
        end
        if (bus.dn_busy) check("busy_timeout", 32'(bus.dn_busy), 32'd0);
    endtask

    task automatic wr_byte(input logic [1:0] sel, input logic [14:0] off, input logic [7:0] d);
        int i;
        wait_idle;
        bus.dn_addr = {sel, off};
        bus.dn_data = d;
        bus.dn_wr   = 1'b1;
        tick;
        bus.dn_wr   = 1'b0;
        if (off >= ROW0 && off < ROW0 + 15'd8) begin
            i = int'(off - ROW0);
            rom_m[sel][i] = d;
        end
    endtask

    // Tick until fetch_ack; DO must not move before the ack cycle.
    task automatic wait_ack(input int lat0, output int lat, output logic [31:0] got);
        logic [31:0] snap;
        logic        stable;
        snap   = get_do();
        stable = 1'b1;
        lat    = lat0;
        do begin
            tick;
            lat++;
            if (!bus.fetch_ack && get_do() != snap) stable = 1'b0;
        end while (!bus.fetch_ack && lat < lat0 + 40);
        if (!bus.fetch_ack) check("ack_timeout", 32'(bus.fetch_ack), 32'd1);
        check("do_no_piecemeal", 32'(stable), 32'd1);
        got = get_do();
    endtask

    task automatic fetch_row(input logic [14:0] a, output int lat, output logic [31:0] got);
        bus.fetch_addr = a;
        bus.fetch_req  = 1'b1;
        tick;
        bus.fetch_req  = 1'b0;
        wait_ack(1, lat, got);
    endtask

    task automatic count_acks(input int cycles, output int acks);
        acks = 0;
        for (int k = 0; k < cycles; k++) begin
            tick;
            if (bus.fetch_ack) acks++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, acks, n, bcnt, wcnt, oebad;
        logic [31:0] got;
        logic [14:0] off;

        wt[0] = '{17'h18005, 8'hA5, 17'h0000B, 1'b0, 1'b1};
        wt[1] = '{17'h00005, 8'h5A, 17'h0000A, 1'b1, 1'b0};
        wt[2] = '{17'h08000, 8'h3C, 17'h00000, 1'b0, 1'b1};
        wt[3] = '{17'h17FFF, 8'hC3, 17'h0FFFF, 1'b1, 1'b0};
        wt[4] = '{17'h1FFFF, 8'h96, 17'h0FFFF, 1'b0, 1'b1};

        bus.dl_active  = 1'b0;
        bus.dn_wr      = 1'b0;
        bus.dn_addr    = '0;
        bus.dn_data    = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        RST_N = 1'b0;
        repeat (3) tick;
        RST_N = 1'b1;
        tick;

        // Reset state
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_ctrl", {28'd0, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'hF);
        check("rst_dq_hiz", 32'(dut.dq_oe), 32'd0);
        check("rst_do", get_do(), 32'h0);
        check("rst_ack_busy", {30'd0, bus.fetch_ack, bus.dn_busy}, 32'd0);

        // Download write mapping vectors
        for (int v = 0; v < 5; v++) begin
            wait_idle;
            bus.dn_addr = wt[v].addr;
            bus.dn_data = wt[v].data;
            bus.dn_wr   = 1'b1;
            tick;
            bus.dn_wr   = 1'b0;
            check($sformatf("wr%0d_addr", v), 32'(sram_addr), 32'(wt[v].exp_waddr));
            check($sformatf("wr%0d_lanes", v), {30'd0, sram_ub_n, sram_lb_n},
                  {30'd0, wt[v].exp_ub_n, wt[v].exp_lb_n});
            check($sformatf("wr%0d_we_oe_set", v), {30'd0, sram_we_n, sram_oe_n}, 32'd3);
            check($sformatf("wr%0d_dq", v),
                  32'(wt[v].exp_ub_n ? sram_dq[7:0] : sram_dq[15:8]), 32'(wt[v].data));
            bcnt = 0; wcnt = 0; oebad = 0; n = 0;
            while (bus.dn_busy && n < 20) begin
                bcnt++;
                if (!sram_we_n) wcnt++;
                if (!sram_oe_n && dut.dq_oe) oebad++;
                tick;
                n++;
            end
            check($sformatf("wr%0d_busy_cycles", v), 32'(bcnt), 32'd5);
            check($sformatf("wr%0d_we_low_cycles", v), 32'(wcnt), 32'd2);
            check($sformatf("wr%0d_oe_vs_dq", v), 32'(oebad), 32'd0);
        end

        // Preload the model window, then the known row at 0x1234
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 8; i++)
                wr_byte(2'(s), ROW0 + 15'(i), 8'($urandom));
        wr_byte(2'd0, 15'h1234, 8'h11);
        wr_byte(2'd1, 15'h1234, 8'h22);
        wr_byte(2'd2, 15'h1234, 8'h33);
        wr_byte(2'd3, 15'h1234, 8'h44);
        wait_idle;
        fetch_row(15'h1234, lat, got);
        check("fetch_lat", 32'(lat), 32'd5);
        check("fetch_data", got, 32'h11223344);
        tick;
        check("ack_one_cycle", 32'(bus.fetch_ack), 32'd0);

        // Collision: write and fetch together, then a dropped write while busy
        wait_idle;
        tick;
        bus.dn_addr    = {2'd3, 15'h1231};
        bus.dn_data    = 8'h77;
        bus.dn_wr      = 1'b1;
        bus.fetch_addr = 15'h1231;
        bus.fetch_req  = 1'b1;
        tick;
        bus.dn_wr      = 1'b0;
        bus.fetch_req  = 1'b0;
        rom_m[3][1]    = 8'h77;
        tick;
        bus.dn_addr    = {2'd0, 15'h1231};
        bus.dn_data    = 8'h99;
        bus.dn_wr      = 1'b1;
        tick;
        bus.dn_wr      = 1'b0;
        wait_ack(3, lat, got);
        check("collide_lat", 32'(lat), 32'd10);
        check("collide_data", got, exp_row(15'h1231));
        wait_idle;
        fetch_row(15'h1231, lat, got);
        check("dropped_write", got, exp_row(15'h1231));

        // Two requests during one read: the later one wins
        wait_idle;
        tick;
        bus.fetch_addr = 15'h1232;
        bus.fetch_req  = 1'b1;
        tick;
        bus.fetch_req  = 1'b0;
        tick;
        bus.fetch_addr = 15'h1233;
        bus.fetch_req  = 1'b1;
        tick;
        bus.fetch_addr = 15'h1235;
        tick;
        bus.fetch_req  = 1'b0;
        wait_ack(4, lat, got);
        check("multi_first_lat", 32'(lat), 32'd5);
        check("multi_first_data", got, exp_row(15'h1232));
        wait_ack(0, lat, got);
        check("multi_latest_data", got, exp_row(15'h1235));
        count_acks(20, acks);
        check("multi_extra_acks", 32'(acks), 32'd0);

        // Fetch while downloading is discarded
        bus.dl_active  = 1'b1;
        bus.fetch_addr = 15'h1230;
        bus.fetch_req  = 1'b1;
        tick;
        bus.fetch_req  = 1'b0;
        count_acks(12, acks);
        bus.dl_active  = 1'b0;
        count_acks(12, n);
        check("dl_active_no_ack", 32'(acks + n), 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            n   = int'($urandom_range(0, 9));
            off = ROW0 + 15'($urandom_range(0, 7));
            if (n < 4) begin
                wr_byte(2'($urandom_range(0, 3)), off, 8'($urandom));
            end else if (n < 9) begin
                fetch_row(off, lat, got);
                check("rand_data", got, exp_row(off));
                check("rand_lat_le10", 32'(lat <= 10), 32'd1);
            end else begin
                wait_idle;
                bus.dl_active  = 1'b1;
                bus.fetch_addr = off;
                bus.fetch_req  = 1'b1;
                tick;
                bus.fetch_req  = 1'b0;
                count_acks(8, acks);
                bus.dl_active  = 1'b0;
                count_acks(8, n);
                check("rand_dl_no_ack", 32'(acks + n), 32'd0);
            end
        end

        // Reset during the WE pulse
        wait_idle;
        bus.dn_addr = {2'd1, 15'h1236};
        bus.dn_data = 8'hEE;
        bus.dn_wr   = 1'b1;
        tick;
        bus.dn_wr   = 1'b0;
        n = 0;
        while (sram_we_n && n < 10) begin
            tick;
            n++;
        end
        check("rst_reached_we_low", 32'(sram_we_n), 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_async_we", 32'(sram_we_n), 32'd1);
        check("rst_async_dq_hiz", 32'(dut.dq_oe), 32'd0);
        check("rst_async_busy", 32'(bus.dn_busy), 32'd0);
        tick;
        tick;
        RST_N = 1'b1;
        tick;
        check("rst_rel_state", 32'(dut.state), 32'(S_IDLE));
        check("rst_rel_busy", 32'(bus.dn_busy), 32'd0);
        check("rst_rel_ctrl", {28'd0, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
